// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage -- memory-access stage of the 5-stage LoongArch pipeline.
//
// Sits between EXE and WB. It latches the EXE->MEM bus and takes load data
// from the synchronous data SRAM. That read was issued by EXE one cycle
// earlier, so the data is present only in the first cycle a load sits in MEM.
// It extracts and extends byte/halfword/word loads, builds the MEM->WB bus,
// and drives a forwarding / load-use bus back to ID.
//
// Ports:
//   clk              rising-edge clock
//   resetn           synchronous reset, active-low
//   exe_to_mem_bus   {load_op[2:0], res_from_mem, gr_we, dest[4:0],
//                     alu_result[31:0], pc[31:0]}
//   exe_to_mem_valid EXE holds a valid instruction for MEM
//   mem_allow_in     MEM accepts a new instruction this cycle
//   mem_to_wb_bus    {gr_we, dest[4:0], final_result[31:0], pc[31:0]}
//   mem_to_wb_valid  MEM presents a valid instruction to WB
//   wb_allow_in      WB accepts this cycle
//   data_sram_rdata  SRAM read data, valid in a load's first MEM cycle only
//   mem_to_id_bus    {fwd_we, fwd_dest[4:0], fwd_data[31:0], fwd_is_load}
// ---------------------------------------------------------------------------
module mem_stage #(
  parameter int EXE_TO_MEM_BUS_WIDTH = 74,
  parameter int MEM_TO_WB_BUS_WIDTH  = 70,
  parameter int MEM_TO_ID_BUS_WIDTH  = 39
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic [EXE_TO_MEM_BUS_WIDTH-1:0] exe_to_mem_bus,
  input  logic                            exe_to_mem_valid,
  output logic                            mem_allow_in,
  output logic [MEM_TO_WB_BUS_WIDTH-1:0]  mem_to_wb_bus,
  output logic                            mem_to_wb_valid,
  input  logic                            wb_allow_in,
  input  logic [31:0]                     data_sram_rdata,
  output logic [MEM_TO_ID_BUS_WIDTH-1:0]  mem_to_id_bus
);

  localparam logic [2:0] LD_B  = 3'b001;
  localparam logic [2:0] LD_H  = 3'b010;
  localparam logic [2:0] LD_BU = 3'b011;
  localparam logic [2:0] LD_HU = 3'b100;

  logic                            mem_valid_r;
  logic [EXE_TO_MEM_BUS_WIDTH-1:0] pipe_r;
  logic                            first_r;
  logic                            hold_vld_r;
  logic [31:0]                     hold_data_r;

  logic        mem_ready_go_s;
  logic        accept_s;
  logic        leave_s;
  logic [2:0]  load_op_s;
  logic        res_from_mem_s;
  logic        gr_we_s;
  logic [4:0]  dest_s;
  logic [31:0] alu_result_s;
  logic [31:0] pc_s;
  logic [31:0] raw_data_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;
  logic [31:0] load_result_s;
  logic [31:0] final_result_s;

  // Field decode of the pipeline register.
  assign load_op_s      = pipe_r[73:71];
  assign res_from_mem_s = pipe_r[70];
  assign gr_we_s        = pipe_r[69];
  assign dest_s         = pipe_r[68:64];
  assign alu_result_s   = pipe_r[63:32];
  assign pc_s           = pipe_r[31:0];

  // Handshake. MEM never stalls by itself.
  assign mem_ready_go_s  = 1'b1;
  assign mem_allow_in    = !mem_valid_r || (mem_ready_go_s && wb_allow_in);
  assign mem_to_wb_valid = mem_valid_r && mem_ready_go_s;
  assign accept_s        = mem_allow_in && exe_to_mem_valid;
  assign leave_s         = mem_to_wb_valid && wb_allow_in;

  // Pipeline register, valid bit, first-cycle flag and held load data.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_valid_r <= 1'b0;
      pipe_r      <= '0;
      first_r     <= 1'b0;
      hold_vld_r  <= 1'b0;
      hold_data_r <= 32'd0;
    end else begin
      if (mem_allow_in) begin
        mem_valid_r <= exe_to_mem_valid;
      end
      if (accept_s) begin
        pipe_r <= exe_to_mem_bus;
      end
      // First-cycle flag lasts exactly one cycle after an accept.
      first_r <= accept_s;
      // SRAM data disappears after the first cycle, so a load stalled at
      // the end of that cycle keeps its own copy until it leaves MEM.
      if (leave_s) begin
        hold_vld_r <= 1'b0;
      end else if (mem_valid_r && first_r && res_from_mem_s && !hold_vld_r) begin
        hold_vld_r  <= 1'b1;
        hold_data_r <= data_sram_rdata;
      end
    end
  end

  assign raw_data_s = hold_vld_r ? hold_data_r : data_sram_rdata;

  // Byte and halfword lane selection by the low address bits.
  always_comb begin
    byte_s = raw_data_s[7:0];
    half_s = raw_data_s[15:0];
    case (alu_result_s[1:0])
      2'd0:    byte_s = raw_data_s[7:0];
      2'd1:    byte_s = raw_data_s[15:8];
      2'd2:    byte_s = raw_data_s[23:16];
      2'd3:    byte_s = raw_data_s[31:24];
      default: byte_s = raw_data_s[7:0];
    endcase
    // addr[0] is deliberately ignored for halfwords (no alignment trap).
    if (alu_result_s[1]) begin
      half_s = raw_data_s[31:16];
    end else begin
      half_s = raw_data_s[15:0];
    end
  end

  // Load extension; unused encodings behave as ld.w.
  always_comb begin
    load_result_s = raw_data_s;
    case (load_op_s)
      LD_B:    load_result_s = {{24{byte_s[7]}}, byte_s};
      LD_BU:   load_result_s = {24'd0, byte_s};
      LD_H:    load_result_s = {{16{half_s[15]}}, half_s};
      LD_HU:   load_result_s = {16'd0, half_s};
      default: load_result_s = raw_data_s;
    endcase
  end

  assign final_result_s = res_from_mem_s ? load_result_s : alu_result_s;

  assign mem_to_wb_bus = {gr_we_s && mem_valid_r, dest_s, final_result_s, pc_s};

  assign mem_to_id_bus = {mem_valid_r && gr_we_s && (dest_s != 5'd0),
                          dest_s,
                          final_result_s,
                          mem_valid_r && res_from_mem_s};

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage -- directed self-checking bench for mem_stage.
// Inputs change 1 time unit after the rising edge; outputs are compared
// 3 time units after the edge, well away from both clock edges.
// ---------------------------------------------------------------------------
module tb_mem_stage;

  logic        clk;
  logic        resetn;
  logic [73:0] exe_to_mem_bus;
  logic        exe_to_mem_valid;
  logic        mem_allow_in;
  logic [69:0] mem_to_wb_bus;
  logic        mem_to_wb_valid;
  logic        wb_allow_in;
  logic [31:0] data_sram_rdata;
  logic [38:0] mem_to_id_bus;

  int n_cmp;
  int n_mis;

  logic [2:0]  op_t   [7];
  logic [1:0]  addr_t [7];
  logic [31:0] exp_t  [7];

  mem_stage dut (
    .clk              (clk),
    .resetn           (resetn),
    .exe_to_mem_bus   (exe_to_mem_bus),
    .exe_to_mem_valid (exe_to_mem_valid),
    .mem_allow_in     (mem_allow_in),
    .mem_to_wb_bus    (mem_to_wb_bus),
    .mem_to_wb_valid  (mem_to_wb_valid),
    .wb_allow_in      (wb_allow_in),
    .data_sram_rdata  (data_sram_rdata),
    .mem_to_id_bus    (mem_to_id_bus)
  );

  // 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [73:0] mk_bus(input logic [2:0] op, input logic rfm,
                                         input logic we, input logic [4:0] dst,
                                         input logic [31:0] alu, input logic [31:0] pc);
    return {op, rfm, we, dst, alu, pc};
  endfunction

  task automatic check_val(input string tag, input logic [69:0] obs, input logic [69:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after inputs were driven.
  task automatic settle();
    #2;
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    resetn           = 1'b0;
    exe_to_mem_valid = 1'b1;
    wb_allow_in      = 1'b1;
    data_sram_rdata  = 32'h0;
    exe_to_mem_bus   = mk_bus(3'b000, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 32'h1C000010);

    op_t   = '{3'b001, 3'b011, 3'b010, 3'b010, 3'b100, 3'b111, 3'b001};
    addr_t = '{2'd2,   2'd3,   2'd0,   2'd2,   2'd3,   2'd0,   2'd0};
    exp_t  = '{32'hFFFFFFFF, 32'h00000080, 32'h00007F01, 32'hFFFF80FF,
               32'h000080FF, 32'h80FF7F01, 32'h00000001};

    // ---- reset with a valid instruction offered ----
    for (int i = 0; i < 2; i++) begin
      tick();
      settle();
      check_val("rst_valid", {69'd0, mem_to_wb_valid}, 70'd0);
      check_val("rst_wb_bus", mem_to_wb_bus, 70'd0);
      check_val("rst_id_bus", {31'd0, mem_to_id_bus}, 70'd0);
      check_val("rst_allow_in", {69'd0, mem_allow_in}, 70'd1);
    end
    resetn = 1'b1;

    // ---- ALU passthrough: accepted on the first edge after reset ----
    tick();
    exe_to_mem_valid = 1'b0;
    settle();
    check_val("alu_valid", {69'd0, mem_to_wb_valid}, 70'd1);
    check_val("alu_wb_bus", mem_to_wb_bus, {1'b1, 5'd5, 32'hDEADBEEF, 32'h1C000010});
    check_val("alu_id_bus", {31'd0, mem_to_id_bus}, {31'd0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0});

    // ---- load extraction from rdata 0x80FF7F01 ----
    for (int i = 0; i < 7; i++) begin
      tick();
      exe_to_mem_bus   = mk_bus(op_t[i], 1'b1, 1'b1, 5'd7, {30'h0700_0000, addr_t[i]}, 32'h1C000100);
      exe_to_mem_valid = 1'b1;
      data_sram_rdata  = 32'h0;
      tick();
      exe_to_mem_valid = 1'b0;
      data_sram_rdata  = 32'h80FF7F01;
      settle();
      check_val($sformatf("ld_extract_%0d", i), {38'd0, mem_to_wb_bus[63:32]}, {38'd0, exp_t[i]});
      if (i == 0) begin
        check_val("ld_is_load", {69'd0, mem_to_id_bus[0]}, 70'd1);
      end
    end

    // ---- stall hold: ld.w stalled 3 cycles while SRAM data changes ----
    tick();
    exe_to_mem_bus   = mk_bus(3'b000, 1'b1, 1'b1, 5'd9, 32'h00001000, 32'h1C000200);
    exe_to_mem_valid = 1'b1;
    tick();
    // next load waits in EXE throughout the stall
    exe_to_mem_bus   = mk_bus(3'b000, 1'b1, 1'b1, 5'd10, 32'h00001004, 32'h1C000204);
    data_sram_rdata  = 32'h12345678;
    wb_allow_in      = 1'b0;
    settle();
    check_val("stall_first", {38'd0, mem_to_wb_bus[63:32]}, {38'd0, 32'h12345678});
    for (int i = 0; i < 3; i++) begin
      tick();
      data_sram_rdata = 32'hAAAAAAAA;
      if (i == 2) begin
        wb_allow_in = 1'b1;
      end
      settle();
      check_val($sformatf("stall_hold_%0d", i), {38'd0, mem_to_wb_bus[63:32]}, {38'd0, 32'h12345678});
      check_val($sformatf("stall_pc_%0d", i), {38'd0, mem_to_wb_bus[31:0]}, {38'd0, 32'h1C000200});
      check_val($sformatf("stall_allow_%0d", i), {69'd0, mem_allow_in}, {69'd0, (i == 2)});
    end
    // departure and accept of the waiting load on the same edge
    tick();
    exe_to_mem_valid = 1'b0;
    data_sram_rdata  = 32'h0BADF00D;
    settle();
    check_val("after_stall_pc", {38'd0, mem_to_wb_bus[31:0]}, {38'd0, 32'h1C000204});
    check_val("after_stall_data", {38'd0, mem_to_wb_bus[63:32]}, {38'd0, 32'h0BADF00D});

    // ---- back-to-back: four ALU instructions, the last with dest=0 ----
    for (int i = 0; i < 4; i++) begin
      exe_to_mem_bus   = mk_bus(3'b000, 1'b0, 1'b1, (i == 3) ? 5'd0 : 5'(i + 1),
                                32'h5000_0000 + 32'(i), 32'h1C000300 + 32'(4 * i));
      exe_to_mem_valid = 1'b1;
      tick();
      settle();
      check_val($sformatf("b2b_valid_%0d", i), {69'd0, mem_to_wb_valid}, 70'd1);
      check_val($sformatf("b2b_pc_%0d", i), {38'd0, mem_to_wb_bus[31:0]}, {38'd0, 32'h1C000300 + 32'(4 * i)});
      check_val($sformatf("b2b_res_%0d", i), {38'd0, mem_to_wb_bus[63:32]}, {38'd0, 32'h5000_0000 + 32'(i)});
      check_val($sformatf("b2b_fwd_we_%0d", i), {69'd0, mem_to_id_bus[38]}, {69'd0, (i != 3)});
    end
    exe_to_mem_valid = 1'b0;
    tick();
    settle();
    check_val("bubble_valid", {69'd0, mem_to_wb_valid}, 70'd0);
    check_val("bubble_gr_we", {69'd0, mem_to_wb_bus[69]}, 70'd0);
    check_val("bubble_fwd_we", {69'd0, mem_to_id_bus[38]}, 70'd0);

    // ---- reset while a held load is stalled ----
    exe_to_mem_bus   = mk_bus(3'b000, 1'b1, 1'b1, 5'd11, 32'h00002000, 32'h1C000400);
    exe_to_mem_valid = 1'b1;
    tick();
    exe_to_mem_valid = 1'b0;
    data_sram_rdata  = 32'h11111111;
    wb_allow_in      = 1'b0;
    tick();
    data_sram_rdata  = 32'h22222222;
    resetn           = 1'b0;
    tick();
    settle();
    check_val("midrst_valid", {69'd0, mem_to_wb_valid}, 70'd0);
    check_val("midrst_wb_bus", mem_to_wb_bus, 70'd0);
    check_val("midrst_id_bus", {31'd0, mem_to_id_bus}, 70'd0);
    resetn           = 1'b1;
    wb_allow_in      = 1'b1;
    exe_to_mem_bus   = mk_bus(3'b000, 1'b1, 1'b1, 5'd12, 32'h00002004, 32'h1C000404);
    exe_to_mem_valid = 1'b1;
    tick();
    exe_to_mem_valid = 1'b0;
    data_sram_rdata  = 32'h33333333;
    settle();
    check_val("postrst_data", {38'd0, mem_to_wb_bus[63:32]}, {38'd0, 32'h33333333});
    check_val("postrst_valid", {69'd0, mem_to_wb_valid}, 70'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage LoongArch pipeline, between EXE and WB.
- Latches the EXE→MEM bus and takes load data from the synchronous data SRAM (read issued by EXE one cycle earlier).
- Extracts and extends byte/halfword/word load data and produces the 70-bit MEM→WB bus.
- Also drives a forwarding/load-use bus to ID and participates in the valid/allow_in pipeline handshake.

Parameters:
EXE_TO_MEM_BUS_WIDTH, 74, width of exe_to_mem_bus
MEM_TO_WB_BUS_WIDTH, 70, width of mem_to_wb_bus
MEM_TO_ID_BUS_WIDTH, 39, width of mem_to_id_bus

Ports:
clk  input  1  clock; all state updates on its rising edge
resetn  input  1  synchronous reset, active-low
exe_to_mem_bus  input  74  {load_op[2:0], res_from_mem, gr_we, dest[4:0], alu_result[31:0], pc[31:0]}, MSB first
exe_to_mem_valid  input  1  EXE holds a valid instruction for MEM
mem_allow_in  output  1  MEM accepts a new instruction this cycle
mem_to_wb_bus  output  70  {gr_we, dest[4:0], final_result[31:0], pc[31:0]}, MSB first
mem_to_wb_valid  output  1  MEM presents a valid instruction to WB
wb_allow_in  input  1  WB accepts this cycle
data_sram_rdata  input  32  SRAM read data, valid only in the first cycle a load occupies MEM
mem_to_id_bus  output  39  {fwd_we, fwd_dest[4:0], fwd_data[31:0], fwd_is_load}, MSB first

Behaviour:
- Reset (resetn=0 at a clock edge):
  - mem_valid←0, held-data valid flag←0, pipeline register←0.
  - Therefore mem_to_wb_valid=0, mem_to_wb_bus=0 and mem_to_id_bus=0 from the following cycle.
  - Reset overrides any simultaneous handshake.
- Handshake:
  - mem_ready_go=1.
  - mem_allow_in = !mem_valid || (mem_ready_go && wb_allow_in).
  - mem_to_wb_valid = mem_valid && mem_ready_go.
  - When mem_allow_in=1: mem_valid←exe_to_mem_valid. The pipeline register loads exe_to_mem_bus only when mem_allow_in && exe_to_mem_valid; otherwise it holds.
  - An accept and a departure in the same cycle is a normal back-to-back transfer with no bubble.
- Load data hold:
  - A first-cycle flag is set on the edge an instruction is accepted and cleared after one cycle in MEM.
  - If the instruction is a load (res_from_mem=1) and is stalled at the end of its first cycle (wb_allow_in=0), data_sram_rdata is captured into hold_data and hold_vld←1.
  - raw_data = hold_vld ? hold_data : data_sram_rdata.
  - hold_vld clears when the instruction leaves MEM (mem_to_wb_valid && wb_allow_in) or on reset.
  - Changes on data_sram_rdata after the first cycle must not affect the result.
- Load extraction (addr = alu_result[1:0]):
  - 000 ld.w: raw_data.
  - 001 ld.b: byte addr, sign-extended.
  - 011 ld.bu: byte addr, zero-extended.
  - 010 ld.h: halfword addr[1], sign-extended.
  - 100 ld.hu: halfword addr[1], zero-extended.
  - Encodings 101–111 are treated as ld.w.
  - addr[0] is ignored for halfword loads. No alignment exception is raised.
- final_result = res_from_mem ? load_result : alu_result.
- mem_to_wb_bus.gr_we = gr_we && mem_valid. dest and pc pass through unchanged. Output is combinational from the register and raw_data; latency is 0 cycles from register to bus.
- mem_to_id_bus:
  - fwd_we = mem_valid && gr_we && dest≠0.
  - fwd_data = final_result.
  - fwd_is_load = mem_valid && res_from_mem; ID uses this for load-use stall decisions.
- Throughput: one instruction per cycle when wb_allow_in=1.

Test Plan:
- Reset: hold resetn=0 for 2 cycles while exe_to_mem_valid=1 → mem_to_wb_valid=0, mem_to_wb_bus=0; the first valid instruction appears one cycle after resetn=1.
- ALU passthrough: pc=0x1C000010, dest=5, gr_we=1, alu_result=0xDEADBEEF, res_from_mem=0 → next cycle bus={1,5,0xDEADBEEF,0x1C000010}, fwd_we=1, fwd_is_load=0.
- Load extract, rdata=0x80FF7F01:
  - ld.b addr=2 → 0xFFFFFFFF.
  - ld.bu addr=3 → 0x00000080.
  - ld.h addr=0 → 0x00007F01.
  - ld.h addr=2 → 0xFFFF80FF.
  - ld.hu addr=3 → 0x000080FF.
  - load_op=111 → 0x80FF7F01.
- Stall hold: ld.w with first-cycle rdata=0x12345678, wb_allow_in=0 for 3 cycles while rdata changes to 0xAAAAAAAA → final_result stays 0x12345678 and mem_allow_in=0; instruction leaves when wb_allow_in=1.
- Back-to-back: 4 valid instructions with wb_allow_in=1 → 4 consecutive mem_to_wb_valid cycles in order; a bubble on exe_to_mem_valid gives mem_to_wb_valid=0 and bus gr_we=0.
- Reset mid-stall: resetn=0 while a held load is stalled → mem_valid=0 and hold_vld=0; the next load uses its fresh first-cycle rdata.
